seq_control: RTL
================

# seq_control

Multi-cycle control sequencer for the 14-bit accumulator datapath: PC counter, instruction and operand registers, adder unit, address mux, synchronous memory and I/O register. It walks each instruction through fetch, decode, operand reads, execute/write-back and output. It drives every register enable and mux/operation select from a registered Moore state machine. It adds run/halt control, an optional single-step mode and a programmable memory read latency.

## Interface

- RD_LAT, 2: cycles from address presented on the mux select to memory data valid at register inputs; legal 1..7.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = execute instructions continuously.
- step  in  1  single-cycle pulse; executes one instruction from IDLE (SEQ_STEP_EN only).
- opcode  in  2  instruction register bits [13:12].
- enmem  out  1  memory write enable.
- enir  out  1  instruction register load.
- enrop1  out  1  operand-1 register load.
- enrop2  out  1  operand-2 register load.
- enrio  out  1  I/O register load.
- enpc  out  1  PC increment.
- seloper  out  2  adder operation select; equals latched opcode.
- selmux  out  2  address source: 00 PC, 01 IR[11:8], 10 IR[7:4], 11 IR[3:0].
- busy  out  1  high in any state except IDLE and HALTED.
- halted  out  1  high in HALTED.

## Operation

- Opcodes:
  - 00 ADD: mem[D] = mem[A] + mem[B].
  - 01 SUB: mem[D] = mem[A] - mem[B].
  - 10 OUT: IO = mem[D].
  - 11 HALT.
- States: IDLE, FETCH, DECODE, RD_A, RD_B, WRITE, OUT, HALTED.
- IDLE: all enables 0, selmux 00. Goes to FETCH when run=1.
- FETCH: selmux 00; a 3-bit wait counter runs from 0. In the cycle where the count equals RD_LAT-1, enir=1 and enpc=1 for exactly that one cycle, then go to DECODE.
- DECODE: latch opcode into the internal op register.
  - 00/01 → RD_A.
  - 10 → OUT.
  - 11 → HALTED.
- RD_A: selmux 01, same wait rule; enrop1 pulses on the last cycle, then RD_B.
- RD_B: selmux 10, same wait rule; enrop2 pulses on the last cycle, then WRITE.
- WRITE: selmux 11, seloper = op, enmem=1 for one cycle.
- OUT: selmux 11, same wait rule; enrio pulses on the last cycle.
- After WRITE or OUT: go to FETCH if run=1, else IDLE.
- run deasserted mid-instruction: the current instruction completes, then the block returns to IDLE. No partial writes.
- HALTED is sticky: all enables 0, halted=1. Only rst exits it.
- seloper outputs the latched op in every state; reset value 00.
- Arithmetic and width rules belong to the adder unit. PC wrap 31→0 is transparent to this block.

## Timing

- All outputs decode from the registered state and wait counter. They change only after a clk edge or on rst assertion.
- Reset values: state IDLE, counter 0, op 00. All enables 0, selmux 00, seloper 00, busy 0, halted 0.
- rst asserted mid-instruction: enables drop in the same cycle (asynchronous). No memory write or register load completes after the edge.
- Cycles per instruction:
  - ADD/SUB: 3·RD_LAT+2 (8 at default).
  - OUT: 2·RD_LAT+1 (5 at default).
  - HALT: RD_LAT+1.
- Exactly one enable pulse per memory access phase. enir and enpc coincide. No other enable is ever active simultaneously with another.
- run sampled on the cycle FETCH is entered from IDLE, and on the last cycle of WRITE/OUT.

## Configuration

- SEQ_STEP_EN defined:
  - In IDLE with run=0, a step pulse runs exactly one instruction and returns to IDLE.
  - step during busy is ignored.
  - step with run=1 behaves as run.
- SEQ_STEP_EN undefined: the step port exists but is ignored; only run starts execution.

## Structure

- Shared package seq_pkg holds:
  - the state enum;
  - opcode constants OP_ADD, OP_SUB, OP_OUT, OP_HALT;
  - selmux codes SEL_PC, SEL_A, SEL_B, SEL_D.
- One sub-module, rd_wait_cnt:
  - 3-bit counter with clear and enable;
  - outputs a done flag when the count equals RD_LAT-1;
  - shared by FETCH, RD_A, RD_B and OUT.

## Test plan

- ADD at default RD_LAT, run=1:
  - rst then run=1, IR fed opcode 00 → enir/enpc at cycle 2, enrop1 at cycle 5, enrop2 at cycle 7, enmem at cycle 8 with selmux=11 and seloper=00;
  - next FETCH at cycle 9.
- OUT then HALT program:
  - opcode 10 → enrio pulse with selmux=11 at cycle 5;
  - opcode 11 → halted=1 after 3 more cycles;
  - run toggling leaves halted=1 until rst.
- run dropped during RD_B of a SUB → enmem still pulses once with seloper=01, then IDLE, busy=0.
- rst asserted during WRITE → enmem falls immediately; after release, state IDLE with all outputs at reset values.
- RD_LAT=4, ADD → 14-cycle instruction; each enable pulse is exactly one cycle wide.
- SEQ_STEP_EN defined, run=0:
  - one step pulse → one complete ADD (8 cycles), then IDLE;
  - a second step during busy is ignored.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the seq_control sequencer
//
// Purpose : state encoding, opcode values and address-mux codes used by
//           seq_control and its wait counter.
// Contents: seq_state_t   - sequencer states
//           OP_*          - instruction opcodes (IR[13:12])
//           SEL_*         - address mux select codes
//           RD_LAT_DEFAULT- default memory read latency in cycles
//           is_wait_state - states that wait on the memory read counter

package seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_RD_A   = 3'd3,
      ST_RD_B   = 3'd4,
      ST_WRITE  = 3'd5,
      ST_OUT    = 3'd6,
      ST_HALTED = 3'd7
   } seq_state_t;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_OUT  = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   localparam logic [1:0] SEL_PC = 2'b00;
   localparam logic [1:0] SEL_A  = 2'b01;
   localparam logic [1:0] SEL_B  = 2'b10;
   localparam logic [1:0] SEL_D  = 2'b11;

   localparam int RD_LAT_DEFAULT = 2;

   // States that present an address and wait RD_LAT cycles for memory data.
   function automatic logic is_wait_state(input seq_state_t s);
      return (s == ST_FETCH) || (s == ST_RD_A) || (s == ST_RD_B) || (s == ST_OUT);
   endfunction

endpackage

// File: rtl/rd_wait_cnt.sv
// rtl/rd_wait_cnt.sv - memory read latency counter shared by all read phases
//
// Purpose: counts cycles spent in a memory read phase and flags the cycle in
//          which read data is valid at the register inputs.
// Ports  : clk  in  - system clock, rising edge
//          rst  in  - asynchronous active-high reset
//          clr  in  - synchronous clear back to 0 (has priority over en)
//          en   in  - count up by one
//          done out - count equals RD_LAT-1
// Params : RD_LAT - read latency in cycles, legal 1..7

module rd_wait_cnt #(
   parameter int RD_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam logic [2:0] LAST = 3'(RD_LAT - 1);

   logic [2:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 3'd0;
      end else if (clr) begin
         count <= 3'd0;
      end else if (en) begin
         count <= count + 3'd1;
      end
   end

   assign done = (count == LAST);

endmodule

// File: rtl/seq_control.sv
// rtl/seq_control.sv - multi-cycle control sequencer for the accumulator datapath
//
// Purpose: walks each instruction through fetch, decode, operand reads,
//          execute/write-back and output, driving every register enable and
//          select of the datapath from a registered Moore state machine.
// Ports  : clk     in   - system clock, rising edge
//          rst     in   - asynchronous active-high reset
//          run     in   - level, 1 = execute instructions continuously
//          step    in   - one-cycle pulse, runs one instruction from IDLE
//          opcode  in 2 - instruction register bits [13:12]
//          enmem   out  - memory write enable
//          enir    out  - instruction register load
//          enrop1  out  - operand-1 register load
//          enrop2  out  - operand-2 register load
//          enrio   out  - I/O register load
//          enpc    out  - PC increment
//          seloper out 2- adder operation select (latched opcode)
//          selmux  out 2- address source: PC, IR[11:8], IR[7:4], IR[3:0]
//          busy    out  - any state other than IDLE and HALTED
//          halted  out  - HALT executed; only rst leaves it
// Params : RD_LAT - cycles from address select to memory data valid, 1..7
// Macro  : SEQ_STEP_EN - when defined, step starts a single instruction from
//          IDLE; when undefined, step is ignored.

module seq_control
   import seq_pkg::*;
#(
   parameter int RD_LAT = RD_LAT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       step,
   input  logic [1:0] opcode,
   output logic       enmem,
   output logic       enir,
   output logic       enrop1,
   output logic       enrop2,
   output logic       enrio,
   output logic       enpc,
   output logic [1:0] seloper,
   output logic [1:0] selmux,
   output logic       busy,
   output logic       halted
);

   seq_state_t state;
   seq_state_t state_next;
   logic [1:0] op;
   logic       rd_done;
   logic       cnt_en;
   logic       cnt_clr;
   logic       start;

   // Start condition out of IDLE. With stepping enabled a step pulse starts
   // one instruction; the end-of-instruction check on run then returns the
   // sequencer to IDLE, so no separate step-mode flag is needed.
`ifdef SEQ_STEP_EN
   assign start = run | step;
`else
   logic step_unused;
   assign step_unused = step;
   assign start       = run;
`endif

   // The counter only advances in read phases and is held at 0 elsewhere so
   // every read phase starts counting from 0. Clearing on done makes the
   // back-to-back phases (RD_A -> RD_B) restart cleanly.
   assign cnt_en  = is_wait_state(state);
   assign cnt_clr = ~cnt_en | rd_done;

   rd_wait_cnt #(
      .RD_LAT (RD_LAT)
   ) u_wait (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .done (rd_done)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Opcode is captured in DECODE, one cycle after the IR load, and held so
   // seloper stays stable through the whole instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op <= OP_ADD;
      end else if (state == ST_DECODE) begin
         op <= opcode;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) state_next = ST_FETCH;
         end
         ST_FETCH: begin
            if (rd_done) state_next = ST_DECODE;
         end
         ST_DECODE: begin
            case (opcode)
               OP_ADD, OP_SUB: state_next = ST_RD_A;
               OP_OUT:         state_next = ST_OUT;
               default:        state_next = ST_HALTED;
            endcase
         end
         ST_RD_A: begin
            if (rd_done) state_next = ST_RD_B;
         end
         ST_RD_B: begin
            if (rd_done) state_next = ST_WRITE;
         end
         // run is only looked at on the last cycle of an instruction, so
         // dropping it mid-instruction still lets the write complete.
         ST_WRITE: begin
            state_next = run ? ST_FETCH : ST_IDLE;
         end
         ST_OUT: begin
            if (rd_done) state_next = run ? ST_FETCH : ST_IDLE;
         end
         ST_HALTED: begin
            state_next = ST_HALTED;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Moore outputs from registered state and counter only; an asynchronous
   // reset therefore drops every enable immediately.
   always_comb begin
      enmem  = 1'b0;
      enir   = 1'b0;
      enrop1 = 1'b0;
      enrop2 = 1'b0;
      enrio  = 1'b0;
      enpc   = 1'b0;
      selmux = SEL_PC;
      halted = 1'b0;
      case (state)
         ST_FETCH: begin
            enir = rd_done;
            enpc = rd_done;
         end
         ST_RD_A: begin
            selmux = SEL_A;
            enrop1 = rd_done;
         end
         ST_RD_B: begin
            selmux = SEL_B;
            enrop2 = rd_done;
         end
         ST_WRITE: begin
            selmux = SEL_D;
            enmem  = 1'b1;
         end
         ST_OUT: begin
            selmux = SEL_D;
            enrio  = rd_done;
         end
         ST_HALTED: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign busy    = (state != ST_IDLE) && (state != ST_HALTED);
   assign seloper = op;

endmodule
